// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Optional build macro SEVEN_SEG_DEC_BLANK_EN makes the all-off pattern a legal digit.
package seven_seg_pkg;

    // Segment patterns are active-low, bit6 = a .. bit0 = g, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seven_seg_decoder_if.sv
// Bundle of the sampled-segment input, the word handshake and the error report.
// Macro SEVEN_SEG_DEC_BLANK_EN adds the blank_mask signal.
interface seven_seg_decoder_if;

    logic [6:0]  seg_in;
    logic [1:0]  dig_idx;
    logic        sample_en;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        err;
    logic [1:0]  err_digit;
`ifdef SEVEN_SEG_DEC_BLANK_EN
    logic [3:0]  blank_mask;
`endif

    modport master (
        output seg_in, dig_idx, sample_en, word_ready,
        input  word_out, word_valid, err, err_digit
`ifdef SEVEN_SEG_DEC_BLANK_EN
        , input blank_mask
`endif
    );

    modport slave (
        input  seg_in, dig_idx, sample_en, word_ready,
        output word_out, word_valid, err, err_digit
`ifdef SEVEN_SEG_DEC_BLANK_EN
        , output blank_mask
`endif
    );

endinterface

// File: rtl/seven_seg_lookup.sv
// Pure combinational map from an active-low segment pattern to {valid, nibble}.
// With SEVEN_SEG_DEC_BLANK_EN the all-off pattern is valid, decodes to 0 and raises blank.
module seven_seg_lookup
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
`ifdef SEVEN_SEG_DEC_BLANK_EN
    output logic       blank,
`endif
    output logic       valid,
    output logic [3:0] nibble
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
`ifdef SEVEN_SEG_DEC_BLANK_EN
        blank = (seg == SEG_ALL_OFF);
        if (blank) begin
            valid  = 1'b1;
            nibble = 4'h0;
        end
`endif
    end

endmodule

// File: rtl/seven_seg_decoder.sv
// Debounces strobed seven-segment samples into four digit registers and hands out 16-bit words.
// Macro SEVEN_SEG_DEC_BLANK_EN accepts all-off digits and reports them on blank_mask.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CNT = 3
)
(
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_decoder_if.slave  bus
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    logic [6:0]      last_pat;
    logic [1:0]      last_idx;
    logic [3:0]      cnt;
    logic [3:0]      cnt_next;
    logic            same;
    logic            hit;
    logic            pat_valid;
    logic [3:0]      pat_nibble;
    logic [3:0][3:0] digits;
    logic [3:0]      captured;
    logic [3:0]      captured_set;
    logic [15:0]     word_q;
    logic            err_q;
    logic [1:0]      err_digit_q;
    logic            load_word;
    state_t          state;
    state_t          state_next;

`ifdef SEVEN_SEG_DEC_BLANK_EN
    logic            pat_blank;
    logic [3:0]      blank_dig;
    logic [3:0]      blank_q;
`endif

    seven_seg_lookup u_lookup (
        .seg    (bus.seg_in),
`ifdef SEVEN_SEG_DEC_BLANK_EN
        .blank  (pat_blank),
`endif
        .valid  (pat_valid),
        .nibble (pat_nibble)
    );

    assign same = (bus.seg_in == last_pat) && (bus.dig_idx == last_idx);

    // A repeat of an already saturated pattern is not a new arrival at the threshold,
    // except at a threshold of one where every strobe stands on its own.
    always_comb begin
        if (!bus.sample_en)      cnt_next = cnt;
        else if (!same)          cnt_next = 4'd1;
        else if (cnt == CNT_MAX) cnt_next = cnt;
        else                     cnt_next = cnt + 4'd1;
        hit = bus.sample_en && (cnt_next == CNT_MAX)
              && (!(same && (cnt == CNT_MAX)) || (STABLE_CNT == 1));
    end

    assign captured_set = (hit && pat_valid) ? (4'b0001 << bus.dig_idx) : 4'b0000;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pat    <= SEG_ALL_OFF;
            last_idx    <= 2'd0;
            cnt         <= 4'd0;
            captured    <= 4'b0000;
            err_q       <= 1'b0;
            err_digit_q <= 2'd0;
        end else begin
            if (bus.sample_en) begin
                last_pat <= bus.seg_in;
                last_idx <= bus.dig_idx;
                cnt      <= cnt_next;
            end
            err_q <= hit && !pat_valid;
            if (hit && !pat_valid) err_digit_q <= bus.dig_idx;
            captured <= (load_word ? 4'b0000 : captured) | captured_set;
        end
    end

    // NOTE: digit storage is left unreset; it is only observable after all four bits of captured are set.
    always_ff @(posedge clk) begin
        if (hit && pat_valid) begin
            digits[bus.dig_idx] <= pat_nibble;
`ifdef SEVEN_SEG_DEC_BLANK_EN
            blank_dig[bus.dig_idx] <= pat_blank;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_word  = 1'b0;
        case (state)
            COLLECT: begin
                if (captured == 4'b1111) begin
                    load_word  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    if (captured == 4'b1111) load_word  = 1'b1;
                    else                     state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= 16'h0000;
`ifdef SEVEN_SEG_DEC_BLANK_EN
            blank_q <= 4'b0000;
`endif
        end else if (load_word) begin
            word_q <= digits;
`ifdef SEVEN_SEG_DEC_BLANK_EN
            blank_q <= blank_dig;
`endif
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state == HOLD);
    assign bus.err        = err_q;
    assign bus.err_digit  = err_digit_q;
`ifdef SEVEN_SEG_DEC_BLANK_EN
    assign bus.blank_mask = blank_q;
`endif

endmodule

// File: doc/seven_seg_decoder.md
SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 3: consecutive identical strobed samples required before a digit is accepted (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port seg_in  input  7  active-low segment pattern, bit6=a .. bit0=g.
REQ-005 SHALL have port dig_idx  input  2  digit position of seg_in (0 = least significant nibble).
REQ-006 SHALL have port sample_en  input  1  one-cycle strobe qualifying seg_in/dig_idx.
REQ-007 SHALL have port word_out  output  16  decoded 4-digit word, digit n in bits [4n+3:4n].
REQ-008 SHALL have port word_valid  output  1  word_out holds a complete, unconsumed word.
REQ-009 SHALL have port word_ready  input  1  consumer accepts word_out when high with word_valid.
REQ-010 SHALL have port err  output  1  one-cycle pulse: stable pattern not in the decode table.
REQ-011 SHALL have port err_digit  output  2  dig_idx of the most recent err pulse, held until the next one.

Function
REQ-012 Decode table (active-low, a..g), 0-F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-013 Filter: last_pat[7], last_idx[2], cnt[4]; on sample_en, same pattern and index as last -> cnt increments, saturating at STABLE_CNT; otherwise last_* reloaded, cnt=1.
REQ-014 Cycle cnt reaches STABLE_CNT (not while already saturated): valid pattern -> nibble into digit register dig_idx, captured[dig_idx] set; invalid -> err pulses the next cycle, err_digit updated, nothing captured.
REQ-015 Re-capturing an already-captured digit overwrites its nibble.
REQ-016 Output FSM, two states: COLLECT (word_valid=0) and HOLD (word_valid=1).
REQ-017 COLLECT -> HOLD when captured==4'b1111: word_out loaded from the digit registers, captured cleared, same edge; word_valid rises one cycle after the fourth capture.
REQ-018 HOLD -> COLLECT on word_valid && word_ready; word_out stable throughout HOLD.
REQ-019 In HOLD, capture continues into the digit registers; a completed frame waits and transfers on the cycle of the handshake (back-to-back valid, no bubble).
REQ-020 sample_en low -> filter state frozen; no timeout.
REQ-021 STABLE_CNT=1 -> every strobed valid pattern captures immediately.

Reset
REQ-022 rst_n low at a clock edge: word_out=0, word_valid=0, err=0, err_digit=0, captured=0, cnt=0, last_pat=7'b1111111, last_idx=0, FSM=COLLECT.
REQ-023 Reset mid-HOLD drops the pending word; no handshake completes on the reset cycle.

Configuration
REQ-024 Macro SEVEN_SEG_DEC_BLANK_EN defined: pattern 1111111 (all off) is a valid digit, decodes to nibble 0, and sets that digit's bit of an extra output blank_mask[3:0], updated together with word_out.
REQ-025 Macro undefined: blank_mask port absent; 1111111 is invalid and raises err.

Structure
REQ-026 Shared package seven_seg_pkg SHALL hold the 16-entry pattern table constant, the active-low all-off constant, and the FSM state typedef.
REQ-027 Sub-module seven_seg_lookup SHALL be the pure combinational pattern-to-{valid, nibble} decoder; filter, digit registers, and FSM stay in the top.

Verification
REQ-028 Digits 3..0 = 1,2,3,4, each strobed 3x -> word_valid rises one cycle after the last capture with word_out=16'h1234; held with word_ready low.
REQ-029 Digit 0 strobed 0000001, 0000001, 1001111, 1001111, 1001111 -> nibble 1 captured, never 0.
REQ-030 Digit 2 strobed 3x with 1111110 -> single err pulse, err_digit=2, no capture; digit register unchanged.
REQ-031 HOLD with word_out=16'hABCD, second frame 16'h00EF completed, word_ready asserted -> next cycle word_out=16'h00EF, word_valid stays high.
REQ-032 rst_n low during HOLD -> next cycle word_valid=0, word_out=0, captured=0; frame restarts from empty.
REQ-033 With SEVEN_SEG_DEC_BLANK_EN: digit 3 all-off, digits 2..0 = 5,6,7 -> word_out=16'h0567, blank_mask=4'b1000, no err.
